// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter and load sequencer for a shared load-enabled holding register.
// Define LOAD_ARB_STATS_EN to add the xfer_count transfer counter output.
module reg_load_arbiter #(
  parameter int K    = 8,
  parameter int N    = 4,
  parameter int HOLD = 3,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*K-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic           reg_load,
  output logic [K-1:0]   reg_data,
  output logic [IDW-1:0] grant_id,
`ifdef LOAD_ARB_STATS_EN
  output logic [15:0]    xfer_count,
`endif
  output logic           busy
);

  localparam int CW = $clog2(HOLD + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [K-1:0]   reg_data_q, reg_data_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;

  logic [2*N-1:0] req_rot;
  logic [IDW-1:0] win;
  logic [K-1:0]   win_data;
  logic           found;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  always_comb begin
    req_rot = {req, req} >> ptr_q;
    win     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        if (int'(ptr_q) + i >= N) win = IDW'(int'(ptr_q) + i - N);
        else                      win = IDW'(int'(ptr_q) + i);
      end
    end
    win_data = '0;
    for (int j = 0; j < N; j++) begin
      if (win == IDW'(j)) win_data = req_data[j*K +: K];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    reg_data_d = reg_data_q;
    grant_id_d = grant_id_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          reg_data_d = win_data;
          grant_id_d = win;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (grant_id_q == IDW'(N - 1)) ptr_d = '0;
        else                           ptr_d = grant_id_q + 1'b1;
        cnt_d   = CW'(HOLD);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      reg_data_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      reg_data_q <= reg_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Load and ack decode from the state flop, so reset drops them asynchronously.
  always_comb begin
    ack = '0;
    for (int i = 0; i < N; i++) begin
      ack[i] = (state_q == S_LOAD) && (grant_id_q == IDW'(i));
    end
  end

  assign reg_load = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign reg_data = reg_data_q;
  assign grant_id = grant_id_q;

`ifdef LOAD_ARB_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (state_q == S_LOAD) xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_count_q <= '0;
    else        xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: doc/reg_load_arbiter.md
Name: reg_load_arbiter

Overview:
Round-robin arbiter and load sequencer for a shared K-bit load-enabled holding register. N requesters offer data; the block grants one at a time, drives the register's data and load inputs, then enforces a hold window so the register output stays stable long enough for downstream synchronisers to sample it. One requester is served per transfer, and each transfer is acknowledged back to its requester.

Parameters:
K, 8, data width of the shared register and of each requester's data
N, 4, number of requesters (N >= 1)
HOLD, 3, idle cycles after each load before the next grant (HOLD >= 1)
IDW (localparam), $clog2(N) with minimum 1, width of grant_id

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  N  request per requester; level, held until ack
req_data  in  N*K  packed data; requester i at [i*K +: K]
ack  out  N  one-hot, one-cycle pulse when requester's data is loaded
reg_load  out  1  drives the shared register's load
reg_data  out  K  drives the shared register's data_in
grant_id  out  IDW  index of the current or most recent grant
busy  out  1  high in LOAD and HOLD states

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: IDLE, round-robin pointer = 0, hold counter = 0.
- Reset values: ack = 0, reg_load = 0, reg_data = 0, grant_id = 0, busy = 0.
- IDLE, any req bit set: pick the first set bit scanning ptr, ptr+1, ... mod N.
  - At that edge: capture req_data of the winner into reg_data, set grant_id, go to LOAD.
- IDLE, req all zero: stay in IDLE; all outputs hold their values (ack and reg_load stay 0).
- LOAD (exactly 1 cycle):
  - reg_load = 1 and ack[grant_id] = 1.
  - ptr <= (grant_id + 1) mod N.
  - Counter <= HOLD, then go to HOLD.
- HOLD: decrement the counter each cycle; when it reaches 1, go to IDLE.
  - Total HOLD dwell is exactly HOLD cycles.
  - req is ignored in this state.
- Latency: req sampled high in IDLE at cycle t gives reg_load and ack in cycle t+1. The shared register updates at the end of t+1.
- Throughput: one transfer every HOLD+2 cycles under continuous demand.
- reg_data changes only at the capture edge. It is stable from capture through the next capture (at least HOLD+2 cycles).
- Data is captured at grant. Changing req_data after the grant does not affect the transfer in progress.
- A requester that keeps req high in the cycle after its ack is treated as a new request, subject to normal round-robin order.
- Dropping req before ack does not cancel a granted transfer; ack is still pulsed.
- N = 1: the pointer is constant 0; behaviour is otherwise identical.
- Reset mid-operation (LOAD or HOLD): the transfer is aborted immediately.
  - No ack is issued and reg_load drops asynchronously.
  - After release, arbitration restarts from ptr = 0.

Optional Feature:
Macro: LOAD_ARB_STATS_EN.
- Defined: adds output port xfer_count [15:0].
  - Increments by 1 on every LOAD cycle and wraps 0xFFFF -> 0x0000.
  - Reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst_n low with random req/req_data -> ack = 0, reg_load = 0, reg_data = 0x00, grant_id = 0, busy = 0. Same result when rst_n is asserted between clock edges.
2. Single request (K=8, N=4, HOLD=3): req = 4'b0100, data[2] = 0xA5 from IDLE at cycle t.
   - Cycle t+1: reg_load = 1, ack = 4'b0100, reg_data = 0xA5, grant_id = 2.
   - busy high for exactly 4 cycles; next grant no earlier than t+5.
3. Fairness: req = 4'b1111 held continuously, data[i] = 0x11*i -> grants 0,1,2,3,0 in order. reg_load pulses exactly 5 cycles apart; reg_data sequence 0x00, 0x11, 0x22, 0x33, 0x00.
4. Pointer: after a grant to 1, req = 4'b1010 -> requester 3 granted before requester 1. Then req = 4'b0011 -> requester 0 granted before requester 1.
5. Reset during HOLD: assert rst_n mid-HOLD.
   - busy and reg_load go low immediately; no ack is pulsed.
   - After release with req = 4'b1001: requester 0 is granted first.
6. With LOAD_ARB_STATS_EN: 6 transfers -> xfer_count = 6. Preload to 0xFFFF via forced transfers, then one more -> 0x0000.
